sseg_scan_ctrl: RTL and testbench
=================================

// Module: sseg_scan_ctrl
// PURPOSE
// - Time-multiplexed scan controller for a NUM_DIGITS-digit common-anode 7-seg display.
// - Shares one hex_to_seven_seg decoder across all digits: steps a digit index, feeds that nibble to the decoder, drives one active-low anode at a time.
// - Inserts a blanking gap between digits to stop ghosting. Sits between the display-value registers and the board pins.
// PARAMETERS
// - NUM_DIGITS   4      digits scanned; digit 0 = value[3:0] (least significant)
// - REFRESH_DIV  50000  clk cycles per digit slot (blank + drive)
// - BLANK_CYCLES 16     cycles per slot with all anodes off; 2 <= BLANK_CYCLES < REFRESH_DIV
// PORTS
// - clk         in   1             system clock; all state on rising edge
// - rst_l       in   1             asynchronous, active-low reset
// - enable      in   1             1 = scanning, 0 = display dark
// - value       in   4*NUM_DIGITS  hex nibbles to display
// - dp          in   NUM_DIGITS    decimal point per digit, active-high
// - digit_en    in   NUM_DIGITS    per-digit enable mask, 1 = shown
// - SSEG_L      out  7             segments GFEDCBA, active-low, registered
// - DP_L        out  1             decimal point, active-low, registered
// - AN_L        out  NUM_DIGITS    anode selects, active-low, at most one low
// - frame_tick  out  1             1-cycle pulse at the end of each full frame
// BEHAVIOUR
// - Reset: AN_L all 1, SSEG_L 7'h7F, DP_L 1, frame_tick 0, index 0, slot counter 0, state IDLE.
// - FSM states: IDLE, BLANK, DRIVE.
// - IDLE: AN_L all 1, SSEG_L 7'h7F. Moves to BLANK with index 0 on the first cycle enable=1.
// - BLANK lasts BLANK_CYCLES cycles with AN_L all 1.
//   - On entry at index 0: snapshot value/dp/digit_en into a frame register (no tearing).
//   - First cycle: drive the decoder with the snapshot nibble for the current index.
//   - Second cycle: register SSEG_L and DP_L. Segments are stable before the anode turns on.
// - DRIVE lasts REFRESH_DIV-BLANK_CYCLES cycles.
//   - AN_L[index]=0 if the snapshot digit_en[index]=1. Otherwise all anodes stay 1; a masked slot still takes full time, so the frame period is constant.
// - End of DRIVE: index increments and the FSM goes to BLANK.
// - Wrap at NUM_DIGITS-1: index returns to 0 and frame_tick=1 for exactly that cycle.
// - Frame period is NUM_DIGITS*REFRESH_DIV cycles.
// - enable=0 in any state: next cycle goes to IDLE, anodes off, index and counter clear. Re-enable always restarts at digit 0 with a fresh snapshot.
// - Changes to value mid-frame are not visible until the next frame's index-0 snapshot.
// - Slot counter width is $clog2(REFRESH_DIV). It must never wrap inside a slot.
// - rst_l asserted mid-scan: all outputs take their reset values immediately (async).
// CONFIGURATION
// - Macro SSEG_LZB_EN enables leading-zero blanking.
// - Defined:
//   - Within the frame snapshot, any digit above the most significant nonzero enabled nibble is forced dark: anode off, SSEG_L 7'h7F.
//   - Digit 0 is always shown, even if the whole value is zero.
//   - dp on a suppressed digit is also suppressed.
// - Undefined: every enabled digit is shown, zeros included.
// STRUCTURE
// - Shared package sseg_pkg:
//   - SSEG_BLANK = 7'h7F
//   - FSM state encoding: IDLE=2'd0, BLANK=2'd1, DRIVE=2'd2
// - Sub-module: one instance of the existing hex_to_seven_seg decoder.
// - Index counter, slot timer, snapshot register and FSM are kept inline.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
// - Reset: rst_l=0 with enable=1 -> AN_L=4'b1111, SSEG_L=7'h7F, DP_L=1, frame_tick=0. Hold after release until enable.
// - Scan: value=16'h12AF, enable=1 -> each slot is 2 dark cycles then 6 cycles low.
//   - AN_L sequence: 1110, 1101, 1011, 0111.
//   - SSEG_L values: 0001110, 0001000, 0100100, 1111001.
//   - frame_tick pulses every 32 cycles.
// - Snapshot: change value to 16'h0000 during digit 1 -> digits 2,3 still show 2,1. Next frame shows 0 on all digits.
// - Mask: digit_en=4'b1011 -> AN_L[2] never low. frame_tick period stays 32.
// - Enable drop mid-DRIVE -> AN_L=4'b1111 next cycle. Re-enable -> first anode low is AN_L[0], after 2 blank cycles.
// - SSEG_LZB_EN: value=16'h0030 -> digits 3,2 dark; digit 1 shows 3 (0110000); digit 0 shows 0 (1000000).
//   - value=0 -> only digit 0 shows.
//   - Without the macro, all four digits light.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants and FSM encoding for the seven-segment scan controller.
package sseg_pkg;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/sseg_scan_ctrl_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order GFEDCBA.
module hex_to_seven_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg_l
);

  always_comb begin
    seg_l = 7'h7F;
    case (hex)
      4'h0: seg_l = 7'h40;
      4'h1: seg_l = 7'h79;
      4'h2: seg_l = 7'h24;
      4'h3: seg_l = 7'h30;
      4'h4: seg_l = 7'h19;
      4'h5: seg_l = 7'h12;
      4'h6: seg_l = 7'h02;
      4'h7: seg_l = 7'h78;
      4'h8: seg_l = 7'h00;
      4'h9: seg_l = 7'h10;
      4'hA: seg_l = 7'h08;
      4'hB: seg_l = 7'h03;
      4'hC: seg_l = 7'h46;
      4'hD: seg_l = 7'h21;
      4'hE: seg_l = 7'h06;
      4'hF: seg_l = 7'h0E;
      default: seg_l = 7'h7F;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              SSEG_L,
  output logic                    DP_L,
  output logic [NUM_DIGITS-1:0]   AN_L,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIGITS - 1);

  scan_state_t             state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_val_q, snap_val_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [NUM_DIGITS-1:0]   an_l_q, an_l_d;
  logic [6:0]              sseg_l_q, sseg_l_d;
  logic                    dp_l_q, dp_l_d;
  logic                    frame_tick_q, frame_tick_d;

  logic [NUM_DIGITS-1:0]   show;
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg_l;
  logic                    load_snap;

`ifdef SSEG_LZB_EN
  logic lzb_seen;

  // Walk down from the top digit; a digit lights once a nonzero enabled nibble is at or above it.
  always_comb begin
    lzb_seen = 1'b0;
    show     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lzb_seen = lzb_seen | (snap_en_q[i] & (snap_val_q[4*i +: 4] != 4'h0));
      show[i]  = snap_en_q[i] & (lzb_seen | (i == 0));
    end
  end
`else
  assign show = snap_en_q;
`endif

  assign cur_nibble = 4'(snap_val_q >> {idx_q, 2'b00});

  hex_to_seven_seg u_dec (
    .hex   (cur_nibble),
    .seg_l (dec_seg_l)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_tick_d = 1'b0;
    load_snap    = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          idx_d     = '0;
          cnt_d     = '0;
          load_snap = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == CNT_SLOT_LAST) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d        = '0;
              frame_tick_d = 1'b1;
              load_snap    = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    snap_val_d = load_snap ? value    : snap_val_q;
    snap_dp_d  = load_snap ? dp       : snap_dp_q;
    snap_en_d  = load_snap ? digit_en : snap_en_q;
  end

  // Segments latch in the first blank cycle so they settle before the anode turns on.
  always_comb begin
    an_l_d   = '1;
    sseg_l_d = sseg_l_q;
    dp_l_d   = dp_l_q;

    if (state_d == DRIVE && show[idx_q]) an_l_d = ~(NUM_DIGITS'(1) << idx_q);

    if (state_d == IDLE) begin
      sseg_l_d = SSEG_BLANK;
      dp_l_d   = 1'b1;
    end else if (state_q == BLANK && cnt_q == '0) begin
      sseg_l_d = show[idx_q] ? dec_seg_l : SSEG_BLANK;
      dp_l_d   = ~(show[idx_q] & snap_dp_q[idx_q]);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_val_q   <= '0;
      snap_dp_q    <= '0;
      snap_en_q    <= '0;
      an_l_q       <= '1;
      sseg_l_q     <= SSEG_BLANK;
      dp_l_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      snap_en_q    <= snap_en_d;
      an_l_q       <= an_l_d;
      sseg_l_q     <= sseg_l_d;
      dp_l_q       <= dp_l_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign SSEG_L     = sseg_l_q;
  assign DP_L       = dp_l_q;
  assign AN_L       = an_l_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed self-checking bench for sseg_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles).
module tb_sseg_scan_ctrl;

`ifdef SSEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        rst_l;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [6:0]  SSEG_L;
  logic        DP_L;
  logic [3:0]  AN_L;
  logic        frame_tick;

  int assertCount = 0;
  int failCount   = 0;

  sseg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .enable     (enable),
    .value      (value),
    .dp         (dp),
    .digit_en   (digit_en),
    .SSEG_L     (SSEG_L),
    .DP_L       (DP_L),
    .AN_L       (AN_L),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [15:0] val,
                               input logic [3:0] dpIn, input logic [3:0] mask);
    enable   = en;
    value    = val;
    dp       = dpIn;
    digit_en = mask;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One full digit slot: two dark cycles, then six cycles with the expected anode pattern.
  task automatic checkSlot(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg,
                           input logic expDp, input logic expTick);
    step();
    checkOutput({tag, "_b0_an"}, 16'(AN_L), 16'hF);
    checkOutput({tag, "_b0_tick"}, 16'(frame_tick), 16'(expTick));
    step();
    checkOutput({tag, "_b1_an"}, 16'(AN_L), 16'hF);
    checkOutput({tag, "_b1_seg"}, 16'(SSEG_L), 16'(expSeg));
    checkOutput({tag, "_b1_dp"}, 16'(DP_L), 16'(expDp));
    checkOutput({tag, "_b1_tick"}, 16'(frame_tick), 16'h0);
    for (int c = 0; c < 6; c++) begin
      step();
      checkOutput({tag, "_drv_an"}, 16'(AN_L), 16'(expAn));
      checkOutput({tag, "_drv_tick"}, 16'(frame_tick), 16'h0);
    end
    checkOutput({tag, "_drv_seg"}, 16'(SSEG_L), 16'(expSeg));
  endtask

  initial begin
    rst_l = 1'b0;
    applyStimulus(1'b1, 16'h12AF, 4'b0100, 4'b1111);
    #22;
    checkOutput("rst_an", 16'(AN_L), 16'hF);
    checkOutput("rst_seg", 16'(SSEG_L), 16'h7F);
    checkOutput("rst_dp", 16'(DP_L), 16'h1);
    checkOutput("rst_tick", 16'(frame_tick), 16'h0);

    enable = 1'b0;
    step();
    rst_l = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("hold_an", 16'(AN_L), 16'hF);
      checkOutput("hold_seg", 16'(SSEG_L), 16'h7F);
    end

    enable = 1'b1;
    checkSlot("f1d0", 4'b1110, 7'h0E, 1'b1, 1'b0);
    checkSlot("f1d1", 4'b1101, 7'h08, 1'b1, 1'b0);
    checkSlot("f1d2", 4'b1011, 7'h24, 1'b0, 1'b0);
    checkSlot("f1d3", 4'b0111, 7'h79, 1'b1, 1'b0);

    checkSlot("f2d0", 4'b1110, 7'h0E, 1'b1, 1'b1);
    checkSlot("f2d1", 4'b1101, 7'h08, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0000, 4'b0000, 4'b1111);
    checkSlot("f2d2", 4'b1011, 7'h24, 1'b0, 1'b0);
    checkSlot("f2d3", 4'b0111, 7'h79, 1'b1, 1'b0);

    checkSlot("f3d0", 4'b1110, 7'h40, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0000, 4'b0000, 4'b1011);
    checkSlot("f3d1", LZB ? 4'b1111 : 4'b1101, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
    checkSlot("f3d2", LZB ? 4'b1111 : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
    checkSlot("f3d3", LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);

    checkSlot("f4d0", 4'b1110, 7'h40, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0030, 4'b0000, 4'b1111);
    checkSlot("f4d1", LZB ? 4'b1111 : 4'b1101, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
    checkSlot("f4d2", 4'b1111, 7'h7F, 1'b1, 1'b0);
    checkSlot("f4d3", LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);

    checkSlot("f5d0", 4'b1110, 7'h40, 1'b1, 1'b1);
    checkSlot("f5d1", 4'b1101, 7'h30, 1'b1, 1'b0);
    checkSlot("f5d2", LZB ? 4'b1111 : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
    checkSlot("f5d3", LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);

    for (int c = 0; c < 4; c++) step();
    checkOutput("pre_drop_an", 16'(AN_L), 16'hE);
    enable = 1'b0;
    step();
    checkOutput("drop_an", 16'(AN_L), 16'hF);
    step();
    checkOutput("drop_an2", 16'(AN_L), 16'hF);
    checkOutput("drop_seg", 16'(SSEG_L), 16'h7F);
    checkOutput("drop_tick", 16'(frame_tick), 16'h0);

    enable = 1'b1;
    checkSlot("re_d0", 4'b1110, 7'h40, 1'b1, 1'b0);
    checkSlot("re_d1", 4'b1101, 7'h30, 1'b1, 1'b0);

    for (int c = 0; c < 4; c++) step();
    rst_l = 1'b0;
    #1;
    checkOutput("async_an", 16'(AN_L), 16'hF);
    checkOutput("async_seg", 16'(SSEG_L), 16'h7F);
    checkOutput("async_dp", 16'(DP_L), 16'h1);
    checkOutput("async_tick", 16'(frame_tick), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
